// File: rtl/acc_stream_out.sv
// acc_stream_out: parallel-to-serial converter. Captures a whole batch of
// VEC_WIDTH words in one handshake and replays it element 0 first over a
// valid/ready stream. A new batch can be taken on the last-word transfer so
// consecutive batches stream without a bubble.
module acc_stream_out #(
  parameter int unsigned VEC_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 16,
  localparam int unsigned IdxW      = (VEC_WIDTH > 1) ? $clog2(VEC_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  batch_valid_i,
  output logic                  batch_ready_o,
  input  logic [DATA_WIDTH-1:0] batch_data_in [0:VEC_WIDTH-1],
  output logic                  stream_valid_o,
  input  logic                  stream_ready_i,
  output logic [DATA_WIDTH-1:0] stream_data_out,
  output logic                  stream_last_o,
  output logic [IdxW-1:0]       stream_idx_o
);

  typedef enum logic {StIdle, StStream} state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(VEC_WIDTH - 1);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] regs_q [0:VEC_WIDTH-1];
  logic [DATA_WIDTH-1:0] regs_d [0:VEC_WIDTH-1];
  logic                  is_last;
  logic                  capture;

  assign is_last = (idx_q == LastIdx);

  // Next-state, batch capture and batch_ready_o. Ready depends combinationally
  // on stream_ready_i during the last word so a new batch can follow directly.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    regs_d        = regs_q;
    capture       = 1'b0;
    batch_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        batch_ready_o = 1'b1;
        if (batch_valid_i) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (stream_ready_i) begin
          if (!is_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            batch_ready_o = 1'b1;
            if (batch_valid_i) begin
              capture = 1'b1;
              idx_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (capture) begin
      regs_d = batch_data_in;
    end
    // No batch may be accepted while reset is asserted.
    if (rst) begin
      batch_ready_o = 1'b0;
    end
  end

  // State, index and batch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
    end
  end

  // Stream outputs: word select by index, forced to zero when idle.
  always_comb begin
    stream_valid_o  = (state_q == StStream);
    stream_last_o   = stream_valid_o && is_last;
    stream_idx_o    = idx_q;
    stream_data_out = '0;
    for (int i = 0; i < VEC_WIDTH; i++) begin
      if (stream_valid_o && (idx_q == IdxW'(i))) begin
        stream_data_out = regs_q[i];
      end
    end
  end

endmodule

// File: tb/tb_acc_stream_out.sv
// Directed bench for acc_stream_out: a VEC_WIDTH=4 instance checked through an
// expected-word scoreboard, plus a VEC_WIDTH=1 instance checked directly.
module tb_acc_stream_out;

  logic        clk = 1'b0;
  logic        rst;

  logic        bv, br, sv, sr, sl;
  logic [15:0] bd [0:3];
  logic [15:0] sd;
  logic [1:0]  sidx;

  logic        bv1, br1, sv1, sr1, sl1;
  logic [15:0] bd1 [0:0];
  logic [15:0] sd1;
  logic [0:0]  sidx1;

  int checks = 0;
  int errors = 0;
  int cycles = 0;
  int xfers  = 0;
  int lasts  = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb_q [$];

  logic        stall_prev = 1'b0;
  logic [15:0] stall_d;
  logic [1:0]  stall_idx;
  logic        stall_l;

  always #5 clk = ~clk;

  acc_stream_out #(.VEC_WIDTH(4), .DATA_WIDTH(16)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .batch_valid_i   (bv),
    .batch_ready_o   (br),
    .batch_data_in   (bd),
    .stream_valid_o  (sv),
    .stream_ready_i  (sr),
    .stream_data_out (sd),
    .stream_last_o   (sl),
    .stream_idx_o    (sidx)
  );

  acc_stream_out #(.VEC_WIDTH(1), .DATA_WIDTH(16)) u_dut1 (
    .clk             (clk),
    .rst             (rst),
    .batch_valid_i   (bv1),
    .batch_ready_o   (br1),
    .batch_data_in   (bd1),
    .stream_valid_o  (sv1),
    .stream_ready_i  (sr1),
    .stream_data_out (sd1),
    .stream_last_o   (sl1),
    .stream_idx_o    (sidx1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then return just after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cycles++;
    if (!rst && bv && br) begin
      for (int i = 0; i < 4; i++) sb_q.push_back({bd[i], 2'(i), (i == 3)});
    end
    if (stall_prev && !rst) begin
      chk("stall_valid", sv, 1);
      chk("stall_data", sd, stall_d);
      chk("stall_idx", sidx, stall_idx);
      chk("stall_last", sl, stall_l);
    end
    stall_prev = !rst && sv && !sr;
    stall_d    = sd;
    stall_idx  = sidx;
    stall_l    = sl;
    if (!rst && sv && sr) begin
      xfers++;
      if (sl) lasts++;
      chk("sb_word_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("word_data", sd, e.d);
        chk("word_idx", sidx, e.idx);
        chk("word_last", sl, e.last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max && sb_q.size() != 0; k++) step();
    chk("drain_done", sb_q.size(), 0);
  endtask

  int c0, x0, l0;

  initial begin
    rst = 1'b1; bv = 1'b0; sr = 1'b1; bd = '{default: 16'h0};
    bv1 = 1'b0; sr1 = 1'b1; bd1 = '{default: 16'h0};
    step(); step();
    chk("rst_valid", sv, 0);
    chk("rst_data", sd, 0);
    chk("rst_last", sl, 0);
    chk("rst_idx", sidx, 0);
    chk("rst_ready_low", br, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", br, 1);

    // Basic stream with the consumer always ready.
    bd = '{16'h0001, 16'h0002, 16'h0003, 16'h0004}; bv = 1'b1;
    step();
    bv = 1'b0; bd = '{default: 16'hDEAD};
    chk("basic_first_valid", sv, 1);
    chk("basic_first_data", sd, 16'h0001);
    chk("basic_first_idx", sidx, 0);
    x0 = xfers; l0 = lasts;
    for (int k = 0; k < 4; k++) step();
    chk("basic_xfers", xfers - x0, 4);
    chk("basic_lasts", lasts - l0, 1);
    chk("basic_end_valid", sv, 0);
    chk("basic_end_ready", br, 1);

    // Backpressure while word 0x0002 is presented.
    bd = '{16'h0001, 16'h0002, 16'h0003, 16'h0004}; bv = 1'b1;
    step();
    bv = 1'b0;
    step();
    sr = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("bp_data", sd, 16'h0002);
    chk("bp_idx", sidx, 1);
    sr = 1'b1;
    drain(8);
    chk("bp_end_valid", sv, 0);

    // Back-to-back batches with no bubble.
    bd = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3}; bv = 1'b1;
    step();
    bv = 1'b0;
    c0 = cycles; x0 = xfers; l0 = lasts;
    for (int k = 0; k < 3; k++) step();
    bd = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3}; bv = 1'b1;
    chk("b2b_ready_last", br, 1);
    step();
    bv = 1'b0;
    chk("b2b_no_bubble", sv, 1);
    chk("b2b_b0", sd, 16'h00B0);
    drain(8);
    chk("b2b_cycles", cycles - c0, 8);
    chk("b2b_xfers", xfers - x0, 8);
    chk("b2b_lasts", lasts - l0, 2);
    chk("b2b_end_valid", sv, 0);

    // Batch offered mid-stream is held off until the last-word transfer.
    bd = '{16'h0010, 16'h0011, 16'h0012, 16'h0013}; bv = 1'b1;
    step();
    bv = 1'b0;
    step();
    bd = '{16'h0020, 16'h0021, 16'h0022, 16'h0023}; bv = 1'b1;
    chk("blk_ready_idx1", br, 0);
    chk("blk_idx1", sidx, 1);
    step();
    chk("blk_ready_idx2", br, 0);
    chk("blk_data_idx2", sd, 16'h0012);
    step();
    chk("blk_ready_last", br, 1);
    step();
    bv = 1'b0;
    chk("blk_new_data", sd, 16'h0020);
    drain(8);
    chk("blk_end_valid", sv, 0);

    // Reset at idx=2 drops the remaining words.
    bd = '{16'h0055, 16'h0066, 16'h0077, 16'h0088}; bv = 1'b1;
    step();
    bv = 1'b0;
    step(); step();
    chk("mid_idx_before_rst", sidx, 2);
    rst = 1'b1;
    step();
    chk("mid_rst_ready", br, 0);
    chk("mid_rst_valid", sv, 0);
    chk("mid_rst_data", sd, 0);
    chk("mid_rst_idx", sidx, 0);
    chk("mid_rst_last", sl, 0);
    sb_q.delete();
    rst = 1'b0;
    #1;
    chk("mid_ready_after", br, 1);
    for (int k = 0; k < 4; k++) step();
    chk("mid_no_replay", sv, 0);

    // VEC_WIDTH=1 instance, including a back-to-back second word.
    bd1 = '{16'hBEEF}; bv1 = 1'b1;
    step();
    chk("v1_valid", sv1, 1);
    chk("v1_data", sd1, 16'hBEEF);
    chk("v1_last", sl1, 1);
    chk("v1_idx", sidx1, 0);
    bd1 = '{16'hCAFE};
    chk("v1_ready_b2b", br1, 1);
    step();
    bv1 = 1'b0;
    chk("v1_b2b_valid", sv1, 1);
    chk("v1_b2b_data", sd1, 16'hCAFE);
    chk("v1_b2b_last", sl1, 1);
    chk("v1_b2b_idx", sidx1, 0);
    step();
    chk("v1_end_valid", sv1, 0);
    chk("v1_end_ready", br1, 1);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
